// File: rtl/dsp_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dsp_pkg                                                      |
// | Description : Shared Z-operand encodings and B-input mode names for the    |
// |               DSP multiply-accumulate slices.                              |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
package dsp_pkg;

    localparam logic [1:0] ZSEL_ZERO = 2'd0;
    localparam logic [1:0] ZSEL_P    = 2'd1;
    localparam logic [1:0] ZSEL_C    = 2'd2;
    localparam logic [1:0] ZSEL_PCIN = 2'd3;

    localparam string B_INPUT_DIRECT  = "DIRECT";
    localparam string B_INPUT_CASCADE = "CASCADE";

endpackage
`default_nettype wire

// File: rtl/dsp_post_adder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dsp_post_adder                                               |
// | Description : Combinational Z +/- (M + carry) with carry-out extraction    |
// |               and optional unsigned saturation.                            |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module dsp_post_adder #(
    parameter int P_W      = 48,
    parameter int SATURATE = 0
) (
    input  logic [P_W-1:0] i_z,
    input  logic [P_W-1:0] i_m,
    input  logic           i_carryin,
    input  logic           i_postsub,
    output logic [P_W-1:0] o_p,
    output logic           o_carry,
    output logic           o_overflow
);

    logic [P_W:0] w_x;
    logic [P_W:0] w_r;

    // One extra bit holds the carry of an add or the borrow of a subtract.
    always_comb begin
        w_x        = {1'b0, i_m} + {{P_W{1'b0}}, i_carryin};
        w_r        = i_postsub ? ({1'b0, i_z} - w_x) : ({1'b0, i_z} + w_x);
        o_carry    = w_r[P_W];
        o_p        = w_r[P_W-1:0];
        o_overflow = 1'b0;
        if ((SATURATE != 0) && w_r[P_W]) begin
            o_p        = i_postsub ? {P_W{1'b0}} : {P_W{1'b1}};
            o_overflow = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dsp_mac_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dsp_mac_pipe                                                 |
// | Description : Three-stage valid-qualified pre-add / multiply / post-add    |
// |               slice with accumulate path and optional saturation.          |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module dsp_mac_pipe
    import dsp_pkg::*;
#(
    parameter int    A_W      = 18,
    parameter int    B_W      = 18,
    parameter int    P_W      = 48,
    parameter string B_INPUT  = "DIRECT",
    parameter int    SATURATE = 0
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               CE,
    input  logic               IN_VALID,
    input  logic               PREADD_EN,
    input  logic               PREADD_SUB,
    input  logic [1:0]         ZSEL,
    input  logic               POSTSUB,
    input  logic               CARRYIN,
    input  logic [A_W-1:0]     A,
    input  logic [B_W-1:0]     B,
    input  logic [B_W-1:0]     D,
    input  logic [B_W-1:0]     BCIN,
    input  logic [P_W-1:0]     C,
    input  logic [P_W-1:0]     PCIN,
    output logic [B_W-1:0]     BCOUT,
    output logic [A_W+B_W-1:0] M,
    output logic [P_W-1:0]     P,
    output logic [P_W-1:0]     PCOUT,
    output logic               CARRYOUT,
    output logic               OVERFLOW,
    output logic               OUT_VALID
);

    localparam int c_m_w     = A_W + B_W;
    localparam bit c_cascade = (B_INPUT == B_INPUT_CASCADE);

    generate
        if (P_W < A_W + B_W) begin : g_width_check
            $error("dsp_mac_pipe: P_W must be at least A_W+B_W");
        end
        if ((B_INPUT != B_INPUT_DIRECT) && (B_INPUT != B_INPUT_CASCADE)) begin : g_b_input_check
            $error("dsp_mac_pipe: B_INPUT must be DIRECT or CASCADE");
        end
    endgenerate

    // Stage 1 registers
    logic [A_W-1:0] r_s1_a;
    logic [B_W-1:0] r_s1_b;
    logic [B_W-1:0] r_s1_d;
    logic [P_W-1:0] r_s1_c;
    logic [P_W-1:0] r_s1_pcin;
    logic           r_s1_preadd_en;
    logic           r_s1_preadd_sub;
    logic [1:0]     r_s1_zsel;
    logic           r_s1_postsub;
    logic           r_s1_carryin;
    logic           r_v1;

    // Stage 2 registers
    logic [c_m_w-1:0] r_s2_m;
    logic [P_W-1:0]   r_s2_c;
    logic [P_W-1:0]   r_s2_pcin;
    logic [1:0]       r_s2_zsel;
    logic             r_s2_postsub;
    logic             r_s2_carryin;
    logic             r_v2;

    // Stage 3 registers
    logic [P_W-1:0] r_p;
    logic           r_carryout;
    logic           r_overflow;
    logic           r_out_valid;

    logic [B_W-1:0]   w_b_sel;
    logic [B_W-1:0]   w_pre;
    logic [c_m_w-1:0] w_prod;
    logic [P_W-1:0]   w_z;
    logic [P_W-1:0]   w_m_ext;
    logic [P_W-1:0]   w_p_next;
    logic             w_carry_next;
    logic             w_overflow_next;

    assign w_b_sel = c_cascade ? BCIN : B;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_s1_a          <= '0;
            r_s1_b          <= '0;
            r_s1_d          <= '0;
            r_s1_c          <= '0;
            r_s1_pcin       <= '0;
            r_s1_preadd_en  <= 1'b0;
            r_s1_preadd_sub <= 1'b0;
            r_s1_zsel       <= ZSEL_ZERO;
            r_s1_postsub    <= 1'b0;
            r_s1_carryin    <= 1'b0;
            r_v1            <= 1'b0;
        end else if (CE) begin
            r_s1_a          <= A;
            r_s1_b          <= w_b_sel;
            r_s1_d          <= D;
            r_s1_c          <= C;
            r_s1_pcin       <= PCIN;
            r_s1_preadd_en  <= PREADD_EN;
            r_s1_preadd_sub <= PREADD_SUB;
            r_s1_zsel       <= ZSEL;
            r_s1_postsub    <= POSTSUB;
            r_s1_carryin    <= CARRYIN;
            r_v1            <= IN_VALID;
        end
    end

    always_comb begin
        w_pre = r_s1_b;
        if (r_s1_preadd_en) begin
            w_pre = r_s1_preadd_sub ? (r_s1_d - r_s1_b) : (r_s1_d + r_s1_b);
        end
        w_prod = c_m_w'(r_s1_a) * c_m_w'(w_pre);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_s2_m       <= '0;
            r_s2_c       <= '0;
            r_s2_pcin    <= '0;
            r_s2_zsel    <= ZSEL_ZERO;
            r_s2_postsub <= 1'b0;
            r_s2_carryin <= 1'b0;
            r_v2         <= 1'b0;
        end else if (CE) begin
            r_s2_m       <= w_prod;
            r_s2_c       <= r_s1_c;
            r_s2_pcin    <= r_s1_pcin;
            r_s2_zsel    <= r_s1_zsel;
            r_s2_postsub <= r_s1_postsub;
            r_s2_carryin <= r_s1_carryin;
            r_v2         <= r_v1;
        end
    end

    // Accumulate reads the live P register, so invalid gaps leave the sum intact.
    always_comb begin
        w_z = '0;
        case (r_s2_zsel)
            ZSEL_P:    w_z = r_p;
            ZSEL_C:    w_z = r_s2_c;
            ZSEL_PCIN: w_z = r_s2_pcin;
            default:   w_z = '0;
        endcase
        w_m_ext = P_W'(r_s2_m);
    end

    dsp_post_adder #(
        .P_W      (P_W),
        .SATURATE (SATURATE)
    ) u_post_adder (
        .i_z        (w_z),
        .i_m        (w_m_ext),
        .i_carryin  (r_s2_carryin),
        .i_postsub  (r_s2_postsub),
        .o_p        (w_p_next),
        .o_carry    (w_carry_next),
        .o_overflow (w_overflow_next)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_p         <= '0;
            r_carryout  <= 1'b0;
            r_overflow  <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (CE) begin
            r_out_valid <= r_v2;
            if (r_v2) begin
                r_p        <= w_p_next;
                r_carryout <= w_carry_next;
                r_overflow <= w_overflow_next;
            end
        end
    end

    assign BCOUT     = r_s1_b;
    assign M         = r_s2_m;
    assign P         = r_p;
    assign PCOUT     = r_p;
    assign CARRYOUT  = r_carryout;
    assign OVERFLOW  = r_overflow;
    assign OUT_VALID = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_dsp_mac_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_dsp_mac_pipe                                              |
// | Description : Directed self-checking bench for dsp_mac_pipe (default,      |
// |               saturating and cascade configurations side by side).         |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_dsp_mac_pipe;
    import dsp_pkg::*;

    localparam int A_W = 18;
    localparam int B_W = 18;
    localparam int P_W = 48;
    localparam logic [P_W-1:0] ONES = {P_W{1'b1}};

    logic           CLK = 1'b0;
    logic           RST_N;
    logic           CE, IN_VALID, PREADD_EN, PREADD_SUB, POSTSUB, CARRYIN;
    logic [1:0]     ZSEL;
    logic [A_W-1:0] A;
    logic [B_W-1:0] B, D, BCIN;
    logic [P_W-1:0] C, PCIN;

    logic [B_W-1:0]     d_bcout, s_bcout, c_bcout;
    logic [A_W+B_W-1:0] d_m, s_m, c_m;
    logic [P_W-1:0]     d_p, s_p, c_p, d_pcout, s_pcout, c_pcout;
    logic               d_co, s_co, c_co, d_ov, s_ov, c_ov, d_vo, s_vo, c_vo;

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    dsp_mac_pipe #(.A_W(A_W), .B_W(B_W), .P_W(P_W), .B_INPUT("DIRECT"), .SATURATE(0)) dut_d (
        .CLK(CLK), .RST_N(RST_N), .CE(CE), .IN_VALID(IN_VALID), .PREADD_EN(PREADD_EN),
        .PREADD_SUB(PREADD_SUB), .ZSEL(ZSEL), .POSTSUB(POSTSUB), .CARRYIN(CARRYIN),
        .A(A), .B(B), .D(D), .BCIN(BCIN), .C(C), .PCIN(PCIN),
        .BCOUT(d_bcout), .M(d_m), .P(d_p), .PCOUT(d_pcout), .CARRYOUT(d_co),
        .OVERFLOW(d_ov), .OUT_VALID(d_vo));

    dsp_mac_pipe #(.A_W(A_W), .B_W(B_W), .P_W(P_W), .B_INPUT("DIRECT"), .SATURATE(1)) dut_s (
        .CLK(CLK), .RST_N(RST_N), .CE(CE), .IN_VALID(IN_VALID), .PREADD_EN(PREADD_EN),
        .PREADD_SUB(PREADD_SUB), .ZSEL(ZSEL), .POSTSUB(POSTSUB), .CARRYIN(CARRYIN),
        .A(A), .B(B), .D(D), .BCIN(BCIN), .C(C), .PCIN(PCIN),
        .BCOUT(s_bcout), .M(s_m), .P(s_p), .PCOUT(s_pcout), .CARRYOUT(s_co),
        .OVERFLOW(s_ov), .OUT_VALID(s_vo));

    dsp_mac_pipe #(.A_W(A_W), .B_W(B_W), .P_W(P_W), .B_INPUT("CASCADE"), .SATURATE(0)) dut_c (
        .CLK(CLK), .RST_N(RST_N), .CE(CE), .IN_VALID(IN_VALID), .PREADD_EN(PREADD_EN),
        .PREADD_SUB(PREADD_SUB), .ZSEL(ZSEL), .POSTSUB(POSTSUB), .CARRYIN(CARRYIN),
        .A(A), .B(B), .D(D), .BCIN(BCIN), .C(C), .PCIN(PCIN),
        .BCOUT(c_bcout), .M(c_m), .P(c_p), .PCOUT(c_pcout), .CARRYOUT(c_co),
        .OVERFLOW(c_ov), .OUT_VALID(c_vo));

    task automatic set_idle();
        CE = 1'b1; IN_VALID = 1'b0; PREADD_EN = 1'b0; PREADD_SUB = 1'b0;
        ZSEL = ZSEL_ZERO; POSTSUB = 1'b0; CARRYIN = 1'b0;
        A = '0; B = '0; D = '0; BCIN = '0; C = '0; PCIN = '0;
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse_reset();
        RST_N = 1'b0;
        #2;
        RST_N = 1'b1;
    endtask

    task automatic test_reset();
        set_idle();
        RST_N = 1'b0;
        #2;
        checks++; if (d_p !== '0) begin failures++; $display("FAIL reset_p got=%0d exp=0", d_p); end
        checks++; if (d_m !== '0) begin failures++; $display("FAIL reset_m got=%0d exp=0", d_m); end
        checks++; if (d_vo !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", d_vo); end
        checks++; if (s_ov !== 1'b0) begin failures++; $display("FAIL reset_ov got=%0b exp=0", s_ov); end
        #1;
        RST_N = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        set_idle();
        A = 18'd8; B = 18'd15; D = 18'd10; C = 48'd10; PREADD_EN = 1'b1; ZSEL = ZSEL_C;
        IN_VALID = 1'b1;
        tick();
        set_idle();
        tick();
        checks++; if (d_m !== 36'd200) begin failures++; $display("FAIL basic_m got=%0d exp=200", d_m); end
        checks++; if (d_vo !== 1'b0) begin failures++; $display("FAIL basic_early_valid got=%0b exp=0", d_vo); end
        tick();
        checks++; if (d_vo !== 1'b1) begin failures++; $display("FAIL basic_valid got=%0b exp=1", d_vo); end
        checks++; if (d_p !== 48'd210) begin failures++; $display("FAIL basic_p got=%0d exp=210", d_p); end
        checks++; if (d_pcout !== 48'd210) begin failures++; $display("FAIL basic_pcout got=%0d exp=210", d_pcout); end
        tick();
        checks++; if (d_vo !== 1'b0) begin failures++; $display("FAIL basic_valid_drop got=%0b exp=0", d_vo); end
    endtask

    task automatic test_preadd_sub();
        set_idle();
        A = 18'd8; D = 18'd20; B = 18'd5; PREADD_EN = 1'b1; PREADD_SUB = 1'b1; IN_VALID = 1'b1;
        tick();
        A = 18'd1; D = 18'd0; B = 18'd1;
        tick();
        set_idle();
        tick();
        checks++; if (d_m !== 36'd262143) begin failures++; $display("FAIL presub_wrap_m got=%0d exp=262143", d_m); end
        checks++; if (d_p !== 48'd120) begin failures++; $display("FAIL presub_p got=%0d exp=120", d_p); end
        tick();
        checks++; if (d_p !== 48'd262143) begin failures++; $display("FAIL presub_wrap_p got=%0d exp=262143", d_p); end
    endtask

    task automatic test_saturation();
        set_idle();
        A = 18'd1; B = 18'd1; C = ONES; ZSEL = ZSEL_C; IN_VALID = 1'b1;
        tick();
        C = '0; POSTSUB = 1'b1;
        tick();
        set_idle();
        tick();
        checks++; if (s_p !== ONES) begin failures++; $display("FAIL sat_add_p got=%0h exp=%0h", s_p, ONES); end
        checks++; if (s_ov !== 1'b1) begin failures++; $display("FAIL sat_add_ov got=%0b exp=1", s_ov); end
        checks++; if (s_co !== 1'b1) begin failures++; $display("FAIL sat_add_co got=%0b exp=1", s_co); end
        checks++; if (d_p !== '0) begin failures++; $display("FAIL wrap_add_p got=%0h exp=0", d_p); end
        checks++; if (d_ov !== 1'b0) begin failures++; $display("FAIL wrap_add_ov got=%0b exp=0", d_ov); end
        checks++; if (d_co !== 1'b1) begin failures++; $display("FAIL wrap_add_co got=%0b exp=1", d_co); end
        tick();
        checks++; if (s_p !== '0) begin failures++; $display("FAIL sat_sub_p got=%0h exp=0", s_p); end
        checks++; if (s_ov !== 1'b1) begin failures++; $display("FAIL sat_sub_ov got=%0b exp=1", s_ov); end
        checks++; if (d_p !== ONES) begin failures++; $display("FAIL wrap_sub_p got=%0h exp=%0h", d_p, ONES); end
    endtask

    task automatic test_cascade();
        set_idle();
        A = 18'd8; B = 18'd15; BCIN = 18'd20; ZSEL = ZSEL_PCIN; PCIN = 48'd30; CARRYIN = 1'b1;
        IN_VALID = 1'b1;
        tick();
        set_idle();
        checks++; if (c_bcout !== 18'd20) begin failures++; $display("FAIL cascade_bcout got=%0d exp=20", c_bcout); end
        checks++; if (d_bcout !== 18'd15) begin failures++; $display("FAIL direct_bcout got=%0d exp=15", d_bcout); end
        tick();
        tick();
        checks++; if (c_p !== 48'd191) begin failures++; $display("FAIL cascade_p got=%0d exp=191", c_p); end
        checks++; if (c_pcout !== 48'd191) begin failures++; $display("FAIL cascade_pcout got=%0d exp=191", c_pcout); end
        checks++; if (d_p !== 48'd151) begin failures++; $display("FAIL direct_pcin_p got=%0d exp=151", d_p); end
    endtask

    task automatic test_accumulate();
        logic [6:0] vpat;
        int         exp_p [7];
        logic [6:0] exp_v;
        vpat  = 7'b0011011;
        exp_v = 7'b1011011;
        exp_p = '{0, 0, 6, 12, 12, 18, 24};
        set_idle();
        pulse_reset();
        tick();
        for (int k = 0; k < 7; k++) begin
            A = 18'd2; B = 18'd3; ZSEL = ZSEL_P; IN_VALID = vpat[k];
            tick();
            if (k >= 2) begin
                checks++;
                if (d_p !== 48'(exp_p[k])) begin failures++; $display("FAIL accum_p[%0d] got=%0d exp=%0d", k, d_p, exp_p[k]); end
                checks++;
                if (d_vo !== exp_v[k-2]) begin failures++; $display("FAIL accum_valid[%0d] got=%0b exp=%0b", k, d_vo, exp_v[k-2]); end
            end
        end
        set_idle();
    endtask

    task automatic test_ce_stall();
        set_idle();
        A = 18'd8; B = 18'd15; D = 18'd10; C = 48'd10; PREADD_EN = 1'b1; ZSEL = ZSEL_C;
        IN_VALID = 1'b1;
        tick();
        set_idle();
        tick();
        CE = 1'b0; IN_VALID = 1'b1; A = 18'd99; B = 18'd1;
        tick();
        tick();
        checks++; if (d_vo !== 1'b0) begin failures++; $display("FAIL ce_frozen_valid got=%0b exp=0", d_vo); end
        set_idle();
        tick();
        checks++; if (d_vo !== 1'b1) begin failures++; $display("FAIL ce_delayed_valid got=%0b exp=1", d_vo); end
        checks++; if (d_p !== 48'd210) begin failures++; $display("FAIL ce_delayed_p got=%0d exp=210", d_p); end
        tick();
        tick();
        checks++; if (d_vo !== 1'b0) begin failures++; $display("FAIL ce_low_capture got=%0b exp=0", d_vo); end
    endtask

    task automatic test_reset_midstream();
        bit seen_valid;
        set_idle();
        A = 18'd3; B = 18'd7; C = 48'd5; ZSEL = ZSEL_C; IN_VALID = 1'b1;
        tick();
        tick();
        tick();
        checks++; if (d_vo !== 1'b1) begin failures++; $display("FAIL midrst_pre_valid got=%0b exp=1", d_vo); end
        #2;
        RST_N = 1'b0;
        #1;
        checks++; if (d_p !== '0) begin failures++; $display("FAIL midrst_p got=%0d exp=0", d_p); end
        checks++; if (d_pcout !== '0) begin failures++; $display("FAIL midrst_pcout got=%0d exp=0", d_pcout); end
        checks++; if (d_bcout !== '0) begin failures++; $display("FAIL midrst_bcout got=%0d exp=0", d_bcout); end
        checks++; if (d_m !== '0) begin failures++; $display("FAIL midrst_m got=%0d exp=0", d_m); end
        checks++; if (d_vo !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%0b exp=0", d_vo); end
        set_idle();
        RST_N = 1'b0;
        #1;
        RST_N = 1'b1;
        seen_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (d_vo === 1'b1) seen_valid = 1'b1;
        end
        checks++; if (seen_valid !== 1'b0) begin failures++; $display("FAIL midrst_ghost_valid got=%0b exp=0", seen_valid); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_preadd_sub();
        test_saturation();
        test_cascade();
        test_accumulate();
        test_ce_stall();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
